// File: rtl/div_top_6_pkg.sv
// div_top_6_pkg: widths, per-stage pipeline record and divide-by-zero constant for the divider.
package div_top_6_pkg;
  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam logic [DIVIDEND_W-1:0] QUO_DZ = '1;
  typedef struct packed {
    logic                  valid;
    logic [DIVISOR_W-1:0]  rem;
    logic [DIVIDEND_W-1:0] quo;
    logic [DIVIDEND_W-1:0] dvd;
    logic [DIVISOR_W-1:0]  dvs;
    logic                  dz;
  } stage_t;
endpackage

// File: rtl/div_cell_6.sv
// div_cell_6: one registered restoring-division step consuming the dividend MSB.
module div_cell_6
  import div_top_6_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  stage_t i_stage,
  output stage_t o_stage
);
  logic [DIVISOR_W:0] w_t;
  logic [DIVISOR_W:0] w_diff;
  logic               w_ge;
  assign w_t    = {i_stage.rem, i_stage.dvd[DIVIDEND_W-1]};
  assign w_diff = w_t - {1'b0, i_stage.dvs};
  assign w_ge   = w_t >= {1'b0, i_stage.dvs};
  // Data only advances with a valid token so the last result holds through bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_stage <= '0;
    end else begin
      o_stage.valid <= i_stage.valid;
      if (i_stage.valid) begin
        o_stage.rem <= w_ge ? w_diff[DIVISOR_W-1:0] : w_t[DIVISOR_W-1:0];
        o_stage.quo <= {i_stage.quo[DIVIDEND_W-2:0], w_ge};
        o_stage.dvd <= {i_stage.dvd[DIVIDEND_W-2:0], 1'b0};
        o_stage.dvs <= i_stage.dvs;
        o_stage.dz  <= i_stage.dz;
      end
    end
  end
endmodule

// File: rtl/div_top_6.sv
// div_top_6: pipelined unsigned restoring divider, one quotient bit per stage, one op per cycle.
module div_top_6
  import div_top_6_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  result_rdy
);
  stage_t w_stage [DIVIDEND_W+1];
  logic   w_unused;
  assign w_stage[0] = '{valid: en, rem: '0, quo: '0, dvd: dividend, dvs: divisor, dz: divisor == '0};
  for (genvar i = 0; i < DIVIDEND_W; i++) begin : g_cell
    div_cell_6 u_cell (
      .clk     (clk),
      .rst     (rst),
      .i_stage (w_stage[i]),
      .o_stage (w_stage[i+1])
    );
  end
  assign quotient    = w_stage[DIVIDEND_W].dz ? QUO_DZ : w_stage[DIVIDEND_W].quo;
  assign remainder   = w_stage[DIVIDEND_W].dz ? '0 : w_stage[DIVIDEND_W].rem;
  assign div_by_zero = w_stage[DIVIDEND_W].dz;
  assign result_rdy  = w_stage[DIVIDEND_W].valid;
  assign w_unused    = ^{w_stage[DIVIDEND_W].dvd, w_stage[DIVIDEND_W].dvs};
endmodule

// File: tb/tb_div_top_6.sv
// tb_div_top_6: directed and random checks of the pipelined divider's results, latency and ordering.
module tb_div_top_6;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        result_rdy;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } exp_t;

  always #5 clk = ~clk;

  div_top_6 dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .result_rdy  (result_rdy)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    en = 1'b0;
    tick();
    tick();
    n_tests++;
    if (quotient !== 16'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data got q=%0d r=%0d dz=%b want q=0 r=0 dz=0", quotient, remainder, div_by_zero);
    end
    n_tests++;
    if (result_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rdy got %b want 0", result_rdy);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single;
    logic exp_rdy;
    for (int c = 0; c < 22; c++) begin
      exp_rdy = (c == 16);
      n_tests++;
      if (result_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL single_rdy c=%0d got %b want %b", c, result_rdy, exp_rdy);
      end
      if (c == 16 || c == 19) begin
        n_tests++;
        if (quotient !== 16'd142 || remainder !== 8'd6 || div_by_zero !== 1'b0) begin
          n_fail++;
          $display("FAIL single_data c=%0d got q=%0d r=%0d dz=%b want q=142 r=6 dz=0", c, quotient, remainder, div_by_zero);
        end
      end
      en = (c == 0);
      dividend = 16'd1000;
      divisor = 8'd7;
      tick();
    end
  endtask

  task automatic test_boundaries;
    logic [15:0] a [4] = '{16'd65535, 16'd65535, 16'd5, 16'd0};
    logic [7:0]  b [4] = '{8'd1, 8'd255, 8'd200, 8'd9};
    logic [15:0] eq [4] = '{16'd65535, 16'd257, 16'd0, 16'd0};
    logic [7:0]  er [4] = '{8'd0, 8'd0, 8'd5, 8'd0};
    logic exp_rdy;
    int k = 0;
    for (int c = 0; c < 24; c++) begin
      exp_rdy = (c >= 16 && c < 20);
      n_tests++;
      if (result_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL bound_rdy c=%0d got %b want %b", c, result_rdy, exp_rdy);
      end
      if (result_rdy === 1'b1 && k < 4) begin
        n_tests++;
        if (quotient !== eq[k] || remainder !== er[k] || div_by_zero !== 1'b0) begin
          n_fail++;
          $display("FAIL bound_data op=%0d got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=0", k, quotient, remainder, div_by_zero, eq[k], er[k]);
        end
        k++;
      end
      en = (c < 4);
      dividend = c < 4 ? a[c] : 16'd0;
      divisor = c < 4 ? b[c] : 8'd0;
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic        e [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] a [5] = '{16'd100, 16'd255, 16'd40000, 16'd0, 16'd7};
    logic [7:0]  b [5] = '{8'd3, 8'd16, 8'd250, 8'd0, 8'd7};
    logic [15:0] eq [4] = '{16'd33, 16'd15, 16'd160, 16'd1};
    logic [7:0]  er [4] = '{8'd1, 8'd15, 8'd0, 8'd0};
    logic exp_rdy;
    int k = 0;
    for (int c = 0; c < 25; c++) begin
      exp_rdy = (c >= 16 && c < 21) ? e[c-16] : 1'b0;
      n_tests++;
      if (result_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL b2b_rdy c=%0d got %b want %b", c, result_rdy, exp_rdy);
      end
      if (result_rdy === 1'b1 && k < 4) begin
        n_tests++;
        if (quotient !== eq[k] || remainder !== er[k] || div_by_zero !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_data op=%0d got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=0", k, quotient, remainder, div_by_zero, eq[k], er[k]);
        end
        k++;
      end
      en = c < 5 ? e[c] : 1'b0;
      dividend = c < 5 ? a[c] : 16'd0;
      divisor = c < 5 ? b[c] : 8'd0;
      tick();
    end
    n_tests++;
    if (k != 4) begin
      n_fail++;
      $display("FAIL b2b_count got %0d want 4", k);
    end
  endtask

  task automatic test_div_zero;
    logic [15:0] eq [2] = '{16'hFFFF, 16'd5};
    logic        ez [2] = '{1'b1, 1'b0};
    logic exp_rdy;
    int k = 0;
    for (int c = 0; c < 21; c++) begin
      exp_rdy = (c == 16 || c == 17);
      n_tests++;
      if (result_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL dz_rdy c=%0d got %b want %b", c, result_rdy, exp_rdy);
      end
      if (result_rdy === 1'b1 && k < 2) begin
        n_tests++;
        if (quotient !== eq[k] || remainder !== 8'd0 || div_by_zero !== ez[k]) begin
          n_fail++;
          $display("FAIL dz_data op=%0d got q=%h r=%0d dz=%b want q=%h r=0 dz=%b", k, quotient, remainder, div_by_zero, eq[k], ez[k]);
        end
        k++;
      end
      en = (c < 2);
      dividend = c == 0 ? 16'd1234 : 16'd10;
      divisor = c == 0 ? 8'd0 : 8'd2;
      tick();
    end
  endtask

  task automatic test_reset_midflight;
    logic exp_rdy;
    for (int c = 0; c < 26; c++) begin
      if (c == 6) begin
        n_tests++;
        if (quotient !== 16'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
          n_fail++;
          $display("FAIL midrst_data got q=%0d r=%0d dz=%b want q=0 r=0 dz=0", quotient, remainder, div_by_zero);
        end
      end
      exp_rdy = (c == 22);
      n_tests++;
      if (result_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL midrst_rdy c=%0d got %b want %b", c, result_rdy, exp_rdy);
      end
      if (c == 22) begin
        n_tests++;
        if (quotient !== 16'd6 || remainder !== 8'd2 || div_by_zero !== 1'b0) begin
          n_fail++;
          $display("FAIL midrst_new got q=%0d r=%0d dz=%b want q=6 r=2 dz=0", quotient, remainder, div_by_zero);
        end
      end
      rst = (c == 5);
      en = (c == 0 || c == 6);
      dividend = c == 0 ? 16'd1000 : 16'd50;
      divisor = c == 0 ? 8'd7 : 8'd8;
      tick();
    end
  endtask

  task automatic test_soak;
    exp_t exp_q [$];
    exp_t x;
    int dens = 50;
    int n_en = 0;
    int n_rdy = 0;
    for (int c = 0; c < 10040; c++) begin
      if (result_rdy === 1'b1) begin
        n_rdy++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL soak_extra c=%0d unexpected result q=%0d r=%0d", c, quotient, remainder);
        end else begin
          x = exp_q.pop_front();
          if (quotient !== x.q || remainder !== x.r || div_by_zero !== x.dz) begin
            n_fail++;
            $display("FAIL soak_data c=%0d got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b", c, quotient, remainder, div_by_zero, x.q, x.r, x.dz);
          end
        end
      end
      if (c % 500 == 0) dens = $urandom_range(10, 100);
      en = (c < 10000) && ($urandom_range(1, 100) <= dens);
      dividend = 16'($urandom_range(0, 65535));
      divisor = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (en) begin
        n_en++;
        x.dz = (divisor == 8'd0);
        x.q = x.dz ? 16'hFFFF : dividend / {8'd0, divisor};
        x.r = x.dz ? 8'd0 : 8'(dividend % {8'd0, divisor});
        exp_q.push_back(x);
      end
      tick();
    end
    en = 1'b0;
    n_tests++;
    if (n_rdy != n_en || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL soak_count got %0d results want %0d", n_rdy, n_en);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_single();
    test_boundaries();
    test_back_to_back();
    test_div_zero();
    test_reset_midflight();
    test_soak();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
